// File: rtl/burst_addr_counter.sv
// Burst address generator for AXI4-style FIXED/INCR/WRAP bursts with beat counting.
// Optional idle-beat watchdog enabled by defining BURST_CNT_TIMEOUT_EN.
module burst_addr_counter #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int BEAT_BYTES = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [1:0]        i_burst,
  input  logic              i_beat,
  input  logic              i_abort,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]  o_count,
  output logic              o_last,
  output logic              o_done,
  output logic              o_err,
  output logic              dbg_state
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(BEAT_BYTES);

  if (TIMEOUT < 1 || BEAT_BYTES < 1 || (BEAT_BYTES & (BEAT_BYTES - 1)) != 0) begin : g_bad_param
    $error("burst_addr_counter: TIMEOUT must be >= 1 and BEAT_BYTES a power of two");
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last;
  logic              start_legal;
  logic              len_ok;
  logic              misaligned;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] next_addr;

`ifdef BURST_CNT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  // WRAP needs a power-of-two window, so only 2/4/8/16-beat bursts on beat-aligned addresses.
  assign len_ok      = (i_len == LEN_W'(1)) || (i_len == LEN_W'(3)) ||
                       (i_len == LEN_W'(7)) || (i_len == LEN_W'(15));
  assign misaligned  = (i_addr & ADDR_W'(BEAT_BYTES - 1)) != '0;
  assign start_legal = (i_burst != 2'b11) &&
                       !((i_burst == BURST_WRAP) && (!len_ok || misaligned));

  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << BEAT_SHIFT) - ADDR_W'(1);

  always_comb begin
    next_addr = addr_q;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = addr_q + BEAT_INC;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + BEAT_INC) & wrap_mask);
      default:     next_addr = addr_q;
    endcase
  end

  assign last = (state_q == S_RUN) && (count_q == len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    burst_d = burst_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef BURST_CNT_TIMEOUT_EN
    wdog_d  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        // A beat arriving alongside a start belongs to no burst yet and is dropped silently.
        if (i_start) begin
          if (start_legal) begin
            state_d = S_RUN;
            addr_d  = i_addr;
            count_d = '0;
            len_d   = i_len;
            burst_d = i_burst;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (i_beat) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_beat) begin
          count_d = count_q + LEN_W'(1);
          addr_d  = next_addr;
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
`ifdef BURST_CNT_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      burst_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef BURST_CNT_TIMEOUT_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`endif

  assign o_busy    = (state_q == S_RUN);
  assign o_addr    = addr_q;
  assign o_count   = count_q;
  assign o_last    = last;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_burst_addr_counter.sv
// Directed bench for burst_addr_counter: INCR/WRAP/FIXED sequences, illegal requests,
// abort, reset mid-burst, and the BURST_CNT_TIMEOUT_EN watchdog when that macro is defined.
module tb_burst_addr_counter;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_start;
  logic [31:0] i_addr;
  logic [7:0]  i_len;
  logic [1:0]  i_burst;
  logic        i_beat;
  logic        i_abort;
  logic        o_busy;
  logic [31:0] o_addr;
  logic [7:0]  o_count;
  logic        o_last;
  logic        o_done;
  logic        o_err;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  burst_addr_counter #(
    .ADDR_W(32), .LEN_W(8), .BEAT_BYTES(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .arst(arst), .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
    .i_burst(i_burst), .i_beat(i_beat), .i_abort(i_abort), .o_busy(o_busy),
    .o_addr(o_addr), .o_count(o_count), .o_last(o_last), .o_done(o_done),
    .o_err(o_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    i_start = 1'b1;
    i_addr  = a;
    i_len   = l;
    i_burst = b;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    arst = 1'b1; i_start = 1'b0; i_addr = '0; i_len = '0; i_burst = '0;
    i_beat = 1'b0; i_abort = 1'b0;
    #3;
    check("rst_busy", o_busy, 0);
    check("rst_addr", o_addr, 0);
    check("rst_count", o_count, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_last", o_last, 0);
    check("rst_state", dbg_state, 0);
    #4 arst = 1'b0;

    // Beat while idle flags an error but moves nothing.
    i_beat = 1'b1;
    tick();
    i_beat = 1'b0;
    check("idle_beat_err", o_err, 1);
    check("idle_beat_busy", o_busy, 0);
    check("idle_beat_addr", o_addr, 0);
    check("idle_beat_count", o_count, 0);

    // INCR 0x100, 4 beats
    start(32'h100, 8'd3, 2'b01);
    check("incr_busy", o_busy, 1);
    check("incr_err_clr", o_err, 0);
    check("incr_a0", o_addr, 32'h100);
    check("incr_c0", o_count, 0);
    check("incr_l0", o_last, 0);
    i_beat = 1'b1;
    tick();
    check("incr_a1", o_addr, 32'h104);
    check("incr_c1", o_count, 1);
    tick();
    check("incr_a2", o_addr, 32'h108);
    check("incr_l2", o_last, 0);
    tick();
    check("incr_a3", o_addr, 32'h10C);
    check("incr_c3", o_count, 3);
    check("incr_l3", o_last, 1);
    check("incr_done_early", o_done, 0);
    tick();
    i_beat = 1'b0;
    check("incr_done", o_done, 1);
    check("incr_idle", o_busy, 0);
    tick();
    check("incr_done_pulse", o_done, 0);

    // WRAP 0x38 len 3 -> 0x38 0x3C 0x30 0x34
    start(32'h38, 8'd3, 2'b10);
    check("wrap_busy", o_busy, 1);
    check("wrap_a0", o_addr, 32'h38);
    i_beat = 1'b1;
    tick();
    check("wrap_a1", o_addr, 32'h3C);
    tick();
    check("wrap_a2", o_addr, 32'h30);
    tick();
    check("wrap_a3", o_addr, 32'h34);
    check("wrap_l3", o_last, 1);
    tick();
    i_beat = 1'b0;
    check("wrap_done", o_done, 1);
    check("wrap_idle", o_busy, 0);

    // Illegal WRAP len 2, then a legal start clears the error
    start(32'h40, 8'd2, 2'b10);
    check("ill_len_busy", o_busy, 0);
    check("ill_len_err", o_err, 1);
    start(32'h200, 8'd1, 2'b01);
    check("legal_clr_err", o_err, 0);
    check("legal_busy", o_busy, 1);

    // Abort on the final beat of INCR len 1
    i_beat = 1'b1;
    tick();
    check("abort_pre_last", o_last, 1);
    check("abort_pre_addr", o_addr, 32'h204);
    i_abort = 1'b1;
    tick();
    i_beat = 1'b0; i_abort = 1'b0;
    check("abort_idle", o_busy, 0);
    check("abort_no_done", o_done, 0);
    tick();
    check("abort_no_done2", o_done, 0);

    // Reserved type, then misaligned WRAP
    start(32'h80, 8'd3, 2'b11);
    check("ill_type_busy", o_busy, 0);
    check("ill_type_err", o_err, 1);
    start(32'h32, 8'd3, 2'b10);
    check("ill_align_busy", o_busy, 0);
    check("ill_align_err", o_err, 1);

    // FIXED len 2, with a start in RUN ignored
    start(32'h40, 8'd2, 2'b00);
    check("fix_busy", o_busy, 1);
    i_beat = 1'b1;
    tick();
    i_beat = 1'b0;
    check("fix_a1", o_addr, 32'h40);
    check("fix_c1", o_count, 1);
    start(32'h999, 8'd0, 2'b01);
    check("run_start_addr", o_addr, 32'h40);
    check("run_start_count", o_count, 1);
    check("run_start_busy", o_busy, 1);
    i_beat = 1'b1;
    tick();
    check("fix_a2", o_addr, 32'h40);
    check("fix_l2", o_last, 1);
    tick();
    i_beat = 1'b0;
    check("fix_done", o_done, 1);

    // len 0: last on first RUN cycle; start+beat in the same idle cycle
    i_beat = 1'b1;
    start(32'h10, 8'd0, 2'b01);
    i_beat = 1'b0;
    check("len0_busy", o_busy, 1);
    check("len0_count", o_count, 0);
    check("len0_last", o_last, 1);
    check("len0_no_err", o_err, 0);
    i_beat = 1'b1;
    tick();
    i_beat = 1'b0;
    check("len0_done", o_done, 1);
    check("len0_idle", o_busy, 0);

    // Reset mid-burst at count 2, start accepted on the first edge after release
    start(32'h400, 8'd3, 2'b01);
    i_beat = 1'b1;
    tick();
    tick();
    i_beat = 1'b0;
    check("pre_rst_count", o_count, 2);
    #1 arst = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_addr", o_addr, 0);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_last", o_last, 0);
    #1 arst = 1'b0;
    start(32'h500, 8'd1, 2'b01);
    check("post_rst_busy", o_busy, 1);
    check("post_rst_addr", o_addr, 32'h500);

`ifdef BURST_CNT_TIMEOUT_EN
    // Beat resets the watchdog, then 8 idle cycles time out
    for (int i = 0; i < 5; i++) tick();
    i_beat = 1'b1;
    tick();
    i_beat = 1'b0;
    check("wd_beat_busy", o_busy, 1);
    for (int i = 0; i < 7; i++) tick();
    check("wd_before", o_busy, 1);
    tick();
    check("wd_busy", o_busy, 0);
    check("wd_err", o_err, 1);
    check("wd_no_done", o_done, 0);
`else
    for (int i = 0; i < 20; i++) tick();
    check("no_wd_busy", o_busy, 1);
    check("no_wd_err", o_err, 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("no_wd_abort", o_busy, 0);
    check("no_wd_no_done", o_done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_addr_counter.md
BURST_ADDR_COUNTER -- requirements
Module: burst_addr_counter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter LEN_W, default 8: burst length field width, in beats-1 (AXI4 encoding).
REQ-003 SHALL have parameter BEAT_BYTES, default 4: bytes per beat, a power of two.
REQ-004 SHALL have parameter TIMEOUT, default 256: idle-beat cycle limit, used only when BURST_CNT_TIMEOUT_EN is defined.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 arst  in  1  reset; asynchronous, active-high.
REQ-007 i_start  in  1  burst request; sampled only in IDLE.
REQ-008 i_addr  in  ADDR_W  burst start address.
REQ-009 i_len  in  LEN_W  number of beats minus 1.
REQ-010 i_burst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 i_beat  in  1  one completed valid&ready data handshake.
REQ-012 i_abort  in  1  cancel the current burst.
REQ-013 o_busy  out  1  burst in progress (state RUN).
REQ-014 o_addr  out  ADDR_W  address of the current beat.
REQ-015 o_count  out  LEN_W  beats completed in the current burst.
REQ-016 o_last  out  1  current beat is the final one (o_busy and o_count==len).
REQ-017 o_done  out  1  one-cycle pulse on burst completion.
REQ-018 o_err  out  1  sticky error flag.

Function
REQ-019 SHALL implement states IDLE and RUN; length, type and address SHALL be registered at start.
REQ-020 In IDLE, i_start with a legal request SHALL enter RUN next cycle with o_addr=i_addr, o_count=0 and o_err cleared.
REQ-021 An illegal request SHALL stay in IDLE and set o_err next cycle: type 11; or WRAP with i_len not in {1,3,7,15} or i_addr not aligned to BEAT_BYTES.
REQ-022 In RUN, each i_beat SHALL increment o_count by 1 and advance o_addr on the same edge.
REQ-023 Address advance: FIXED unchanged; INCR o_addr+BEAT_BYTES modulo 2^ADDR_W; WRAP increments within the aligned (len+1)*BEAT_BYTES window, with the upper bits held.
REQ-024 o_last SHALL be combinational from registers; len=0 SHALL assert o_last on the first RUN cycle.
REQ-025 i_beat while o_last=1 SHALL return to IDLE and pulse o_done for exactly the following cycle.
REQ-026 i_start in RUN SHALL be ignored.
REQ-027 i_beat in IDLE SHALL set o_err and leave the count and address unchanged.
REQ-028 i_abort in RUN SHALL return to IDLE next cycle with no o_done; if it coincides with the final beat, abort SHALL win.
REQ-029 i_start and i_beat in the same IDLE cycle SHALL start the burst, and that i_beat SHALL be ignored without setting o_err.
REQ-030 o_err SHALL remain set until the next accepted legal i_start or reset.

Reset
REQ-031 arst SHALL force IDLE immediately, with o_busy=0, o_addr=0, o_count=0, o_done=0 and o_err=0, including mid-burst.
REQ-032 After arst deasserts, the first i_start SHALL be accepted on the first clk edge.

Configuration
REQ-033 With macro BURST_CNT_TIMEOUT_EN defined, TIMEOUT consecutive RUN cycles without i_beat SHALL force IDLE and set o_err, with no o_done.
REQ-034 With BURST_CNT_TIMEOUT_EN defined, the watchdog counter SHALL clear on every i_beat and on every start.
REQ-035 Without BURST_CNT_TIMEOUT_EN, no watchdog logic SHALL exist and RUN SHALL persist indefinitely.

Verification
REQ-036 INCR: addr 0x100, len 3, 4 beats -> o_addr 0x100/0x104/0x108/0x10C, o_last on the 4th beat, o_done one cycle after it.
REQ-037 WRAP: addr 0x38, len 3, BEAT_BYTES 4 -> o_addr 0x38/0x3C/0x30/0x34, then o_done.
REQ-038 Illegal requests: WRAP len 2, or type 11 -> o_busy stays 0 and o_err=1 next cycle; a following legal start clears o_err.
REQ-039 Abort coincident with the final beat of an INCR len 1 burst -> IDLE, o_done stays 0.
REQ-040 arst asserted mid-burst at count 2 -> all outputs zero immediately; a new start is accepted on the next edge.
REQ-041 With BURST_CNT_TIMEOUT_EN and TIMEOUT=8: start, then no beats -> o_busy drops after 8 cycles with o_err=1.
